// File: rtl/memctrl_pkg.sv
// Shared types and limits for the MEMCTRL host-side initiator.
package memctrl_pkg;

    localparam int unsigned AW_DEF     = 16;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned RD_LAT_MAX = 7;
    localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } state_e;

    // MEMCTRL control strobes, kept together so they always move as one register
    typedef struct packed {
        logic ce;
        logic csb;
        logic web;
        logic oeb;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{ce: 1'b0, csb: 1'b1, web: 1'b1, oeb: 1'b1};

    // Selected-device strobes for a write or a read access
    function automatic strobe_t strobe_sel(input logic write);
        strobe_t s;
        s.ce  = 1'b1;
        s.csb = 1'b0;
        s.web = !write;
        s.oeb = write;
        return s;
    endfunction

endpackage

// File: rtl/mem_host_beat_cnt.sv
// Read-latency down-counter and burst beat counter, each with a registered zero flag.
module mem_host_beat_cnt
    import memctrl_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lat_load_i,
    input  logic             lat_dec_i,
    input  logic             beat_load_i,
    input  logic [LEN_W-1:0] beat_len_i,
    input  logic             beat_dec_i,
    output logic             lat_zero_o,
    output logic             beat_zero_o
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic             lat_zero_q, lat_zero_d;
    logic [LEN_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic             beat_zero_q, beat_zero_d;

    // Zero flags are computed alongside the count so they are valid the cycle after load
    always_comb begin
        lat_cnt_d   = lat_cnt_q;
        lat_zero_d  = lat_zero_q;
        beat_cnt_d  = beat_cnt_q;
        beat_zero_d = beat_zero_q;

        if (lat_load_i) begin
            lat_cnt_d  = LAT_INIT;
            lat_zero_d = (LAT_INIT == '0);
        end else if (lat_dec_i && !lat_zero_q) begin
            lat_cnt_d  = lat_cnt_q - LAT_W'(1);
            lat_zero_d = (lat_cnt_q == LAT_W'(1));
        end

        if (beat_load_i) begin
            beat_cnt_d  = beat_len_i;
            beat_zero_d = (beat_len_i == '0);
        end else if (beat_dec_i && !beat_zero_q) begin
            beat_cnt_d  = beat_cnt_q - LEN_W'(1);
            beat_zero_d = (beat_cnt_q == LEN_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_cnt_q   <= '0;
            lat_zero_q  <= 1'b1;
            beat_cnt_q  <= '0;
            beat_zero_q <= 1'b1;
        end else begin
            lat_cnt_q   <= lat_cnt_d;
            lat_zero_q  <= lat_zero_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_zero_q <= beat_zero_d;
        end
    end

    assign lat_zero_o  = lat_zero_q;
    assign beat_zero_o = beat_zero_q;

endmodule

// File: rtl/mem_host_master.sv
// Host-side initiator turning a valid/ready request stream into registered MEMCTRL SRAM strobes.
// Build option: MEMHOST_BURST_EN honours REQ_LEN (1..256 beats); otherwise every request is one beat.
module mem_host_master
    import memctrl_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_WRITE,
    input  logic [AW-1:0]    REQ_ADDR,
    input  logic [DW-1:0]    REQ_WDATA,
    input  logic [LEN_W-1:0] REQ_LEN,
    output logic             RSP_VALID,
    output logic [DW-1:0]    RSP_RDATA,
    output logic             RSP_LAST,
    output logic             BUSY,
    output logic [AW-1:0]    ADDR,
    output logic             CE,
    output logic             CSB,
    output logic             WEB,
    output logic             OEB,
    output logic [DW-1:0]    IDATA,
    input  logic [DW-1:0]    ODATA
);

    state_e           state_q, state_d;
    strobe_t          strb_q, strb_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    idata_q, idata_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_last_q, rsp_last_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic             lat_load, lat_dec, lat_zero;
    logic             beat_load, beat_dec, beat_zero;
    logic [LEN_W-1:0] beat_len;
    logic             accept;

`ifdef MEMHOST_BURST_EN
    localparam logic BURST = 1'b1;
    assign beat_len = REQ_LEN;
`else
    localparam logic BURST = 1'b0;
    logic unused_len;
    assign beat_len   = '0;
    assign unused_len = ^REQ_LEN;
`endif

    assign REQ_READY = (state_q == ST_IDLE) && !RST;
    assign accept    = REQ_VALID && REQ_READY;

    mem_host_beat_cnt #(
        .RD_LAT (RD_LAT)
    ) u_beat_cnt (
        .clk_i       (CLK),
        .rst_i       (RST),
        .lat_load_i  (lat_load),
        .lat_dec_i   (lat_dec),
        .beat_load_i (beat_load),
        .beat_len_i  (beat_len),
        .beat_dec_i  (beat_dec),
        .lat_zero_o  (lat_zero),
        .beat_zero_o (beat_zero)
    );

    // Next-state and next-output logic; strobes default to deselected every cycle
    always_comb begin
        state_d     = state_q;
        strb_d      = STROBE_IDLE;
        addr_d      = addr_q;
        idata_d     = idata_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;
        beat_load   = 1'b0;
        beat_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_CMD;
                    addr_d    = REQ_ADDR;
                    wr_d      = REQ_WRITE;
                    beat_load = 1'b1;
                    strb_d    = strobe_sel(REQ_WRITE);
                    if (REQ_WRITE) begin
                        idata_d = REQ_WDATA;
                    end
                end
            end
            ST_CMD: begin
                if (wr_q) begin
                    if (beat_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_NEXT;
                        beat_dec = 1'b1;
                        addr_d   = addr_q + AW'(1);
                    end
                end else begin
                    state_d  = ST_WAIT;
                    lat_load = 1'b1;
                    strb_d   = strobe_sel(1'b0);
                end
            end
            ST_WAIT: begin
                if (lat_zero) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ODATA;
                    rsp_last_d  = BURST ? beat_zero : 1'b1;
                    if (beat_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_NEXT;
                        beat_dec = 1'b1;
                        addr_d   = addr_q + AW'(1);
                    end
                end else begin
                    lat_dec = 1'b1;
                    strb_d  = strobe_sel(1'b0);
                end
            end
            ST_NEXT: begin
                // One deselect cycle done; the next beat re-samples the held write data
                state_d = ST_CMD;
                strb_d  = strobe_sel(wr_q);
                if (wr_q) begin
                    idata_d = REQ_WDATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            strb_q      <= STROBE_IDLE;
            addr_q      <= '0;
            idata_q     <= '0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            strb_q      <= strb_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign CE        = strb_q.ce;
    assign CSB       = strb_q.csb;
    assign WEB       = strb_q.web;
    assign OEB       = strb_q.oeb;
    assign ADDR      = addr_q;
    assign IDATA     = idata_q;
    assign BUSY      = busy_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_LAST  = rsp_last_q;
    assign RSP_RDATA = rsp_rdata_q;

endmodule
